tlb_op_ctrl: RTL
================

Name: tlb_op_ctrl

Overview:
CP0-side initiator for TLB maintenance instructions (TLBR, TLBWI, TLBWR, TLBP). It sits between the MEM-stage CP0 logic and the TLB's request port. It latches CP0 operands, drives tlb_req/tlb_info until tlb_ok, then writes results back to CP0 Index/EntryHi/EntryLo0/EntryLo1. It owns the CP0 Random register and stalls the pipeline for the duration of each operation.

Parameters:
TLBEntries, 32, number of TLB entries; Random range is [cp0_wired, TLBEntries-1].
TIMEOUT, 15, maximum cycles in REQ without tlb_ok before aborting.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  MEM stage holds a TLB instruction
op_type  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
flush  in  1  exception/eret squash of the MEM stage
cp0_index  in  32  CP0 Index
cp0_entryhi  in  32  CP0 EntryHi
cp0_entrylo0  in  32  CP0 EntryLo0
cp0_entrylo1  in  32  CP0 EntryLo1
cp0_wired  in  5  CP0 Wired
wired_we  in  1  MTC0 to Wired this cycle
tlb_req  out  tlb_req_t  request to the TLB (NO_REQ when idle)
tlb_info  out  tlb_t  operands to the TLB
tlb_ok  in  1  TLB completion pulse
tlb_res  in  tlb_t  TLB result (entryhi/entrylo0/entrylo1/index)
stall  out  1  hold the pipeline
wb_hi_lo_we  out  1  write wb_entryhi/wb_entrylo0/wb_entrylo1 into CP0 (TLBR)
wb_entryhi  out  32  EntryHi writeback value
wb_entrylo0  out  32  EntryLo0 writeback value
wb_entrylo1  out  32  EntryLo1 writeback value
wb_index_we  out  1  write wb_index into CP0 Index (TLBP)
wb_index  out  32  Index writeback value; bit31 = P (probe miss)
random  out  5  CP0 Random register
op_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values: state IDLE, tlb_req=NO_REQ, tlb_info all zero, stall=0, all wb_* and op_err 0, random=TLBEntries-1, timeout counter 0.
- States: IDLE, REQ, WB, GUARD.
- IDLE: if op_valid && !flush, go to REQ and latch the operands in that cycle.
  - Latched into tlb_info: entryhi=cp0_entryhi, entrylo0=cp0_entrylo0, entrylo1=cp0_entrylo1, pagemask=0.
  - tlb_info.index = {27'b0, random} for TLBWR; cp0_index otherwise.
  - Latch op_type. Clear the timeout counter.
- REQ: tlb_req is driven from the latched op (TLBR/TLBWI/TLBWR/TLBP) every cycle; tlb_info is held stable.
  - On tlb_ok=1: capture tlb_res into the wb_* value registers and go to WB.
  - Else if the counter reaches TIMEOUT: pulse op_err and go to GUARD.
  - Else increment the counter.
- WB (exactly 1 cycle): tlb_req=NO_REQ.
  - TLBR: wb_hi_lo_we=1.
  - TLBP: wb_index_we=1; wb_index = tlb_res.index (bit31 set on miss, low bits = hit index).
  - TLBWI/TLBWR: no write enables.
  - Next state GUARD.
- GUARD (exactly 1 cycle): tlb_req=NO_REQ; lets the responder return to idle after a possible re-sample of the request. Next state IDLE.
- stall = (IDLE && op_valid && !flush) || REQ. Stall is low in WB, so the instruction retires in the same cycle the CP0 write enables fire.
  - In GUARD, stall=1 only if op_valid && !flush; the next op starts from IDLE afterwards.
- tlb_req is only non-NO_REQ in REQ. It drops in the cycle after tlb_ok is sampled, and tlb_ok is ignored outside REQ.
- flush: in IDLE it blocks the start. In REQ/WB/GUARD it is ignored, because the op is committed and must complete its writeback.
- Random register:
  - Each cycle: if wired_we, random=TLBEntries-1; else if random==cp0_wired, random=TLBEntries-1; else random-1.
  - If cp0_wired > TLBEntries-1, random stays at TLBEntries-1.
  - Random updates every cycle, including during a stall. The TLBWR index is the value sampled on the IDLE->REQ edge.
- Reset mid-operation: go to IDLE immediately with all outputs at reset values; no writeback occurs.
- Arithmetic: the timeout counter is $clog2(TIMEOUT+1) bits; random is 5 bits, unsigned compare.

Test Plan:
- TLBP hit: entryhi=0x0040_2005, TLB returns index=3 with tlb_ok at the 2nd REQ cycle -> one wb_index_we pulse with wb_index=0x0000_0003; stall high exactly 3 cycles; tlb_req=NO_REQ in WB/GUARD.
- TLBP miss: tlb_res.index=0x8000_0000 -> wb_index=0x8000_0000; wb_hi_lo_we stays 0.
- TLBR: index=7, tlb_res entryhi=0x1234_E0AB, entrylo0=0x0000_1F1E, entrylo1=0x0000_2F1E -> wb_hi_lo_we pulse with exactly those values; wb_index_we=0.
- TLBWR plus Random: wired=4, reset, count cycles -> random runs 31,30,...,4,31. Issuing TLBWR when random=9 -> tlb_info.index=9 for the whole REQ phase, even though random keeps decrementing.
- Flush and timeout:
  - op_valid with flush=1 in IDLE -> no request, stall=0.
  - tlb_ok never arrives -> op_err pulses after 16 REQ cycles, then IDLE with no wb enables.
- Reset in REQ with TLBWI pending -> next cycle tlb_req=NO_REQ, stall=0, state IDLE; a later op completes normally.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// CP0-side initiator for TLBR/TLBWI/TLBWR/TLBP: latches CP0 operands, handshakes with the TLB,
// writes results back to CP0 and maintains the Random register.

package tlb_op_pkg;
   typedef enum logic [2:0] {
      NO_REQ    = 3'd0,
      REQ_TLBR  = 3'd1,
      REQ_TLBWI = 3'd2,
      REQ_TLBWR = 3'd3,
      REQ_TLBP  = 3'd4
   } tlb_req_t;

   typedef struct packed {
      logic [31:0] entryhi;
      logic [31:0] pagemask;
      logic [31:0] entrylo0;
      logic [31:0] entrylo1;
      logic [31:0] index;
   } tlb_t;

   localparam logic [1:0] OP_TLBR  = 2'b00;
   localparam logic [1:0] OP_TLBWI = 2'b01;
   localparam logic [1:0] OP_TLBWR = 2'b10;
   localparam logic [1:0] OP_TLBP  = 2'b11;
endpackage

module tlb_op_ctrl
   import tlb_op_pkg::*;
#(
   parameter int unsigned TLBEntries = 32,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_type,
   input  logic        flush,
   input  logic [31:0] cp0_index,
   input  logic [31:0] cp0_entryhi,
   input  logic [31:0] cp0_entrylo0,
   input  logic [31:0] cp0_entrylo1,
   input  logic [4:0]  cp0_wired,
   input  logic        wired_we,
   output tlb_req_t    tlb_req,
   output tlb_t        tlb_info,
   input  logic        tlb_ok,
   input  tlb_t        tlb_res,
   output logic        stall,
   output logic        wb_hi_lo_we,
   output logic [31:0] wb_entryhi,
   output logic [31:0] wb_entrylo0,
   output logic [31:0] wb_entrylo1,
   output logic        wb_index_we,
   output logic [31:0] wb_index,
   output logic [4:0]  random,
   output logic        op_err
);

   localparam int unsigned     CntW       = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
   localparam logic [4:0]      RandMax    = 5'(TLBEntries - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWb, StGuard} state_e;

   state_e          state_q, state_d;
   logic [1:0]      op_q;
   tlb_t            info_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      random_q, random_d;
   logic [31:0]     wb_hi_q, wb_lo0_q, wb_lo1_q, wb_idx_q;
   logic            op_err_q, op_err_d;
   logic            start, latch, capture;
   logic            unused_pagemask;

   assign start           = op_valid && !flush;
   assign unused_pagemask = ^tlb_res.pagemask;

   // Random reloads on an MTC0 to Wired, on reaching Wired, or when Wired is out of range.
   always_comb begin
      random_d = random_q - 5'd1;
      if (wired_we || (random_q == cp0_wired) || (32'(cp0_wired) >= TLBEntries)) begin
         random_d = RandMax;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_err_d    = 1'b0;
      latch       = 1'b0;
      capture     = 1'b0;
      tlb_req     = NO_REQ;
      stall       = 1'b0;
      wb_hi_lo_we = 1'b0;
      wb_index_we = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StReq;
               latch   = 1'b1;
               cnt_d   = '0;
               stall   = 1'b1;
            end
         end
         StReq: begin
            stall = 1'b1;
            unique case (op_q)
               OP_TLBR:  tlb_req = REQ_TLBR;
               OP_TLBWI: tlb_req = REQ_TLBWI;
               OP_TLBWR: tlb_req = REQ_TLBWR;
               default:  tlb_req = REQ_TLBP;
            endcase
            if (tlb_ok) begin
               capture = 1'b1;
               state_d = StWb;
            end else if (cnt_q == TimeoutCnt) begin
               op_err_d = 1'b1;
               state_d  = StGuard;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWb: begin
            wb_hi_lo_we = (op_q == OP_TLBR);
            wb_index_we = (op_q == OP_TLBP);
            state_d     = StGuard;
         end
         default: begin
            // Give the responder a cycle to drop back to idle before a new request.
            stall   = start;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= 2'b00;
         info_q   <= '0;
         cnt_q    <= '0;
         random_q <= RandMax;
         wb_hi_q  <= '0;
         wb_lo0_q <= '0;
         wb_lo1_q <= '0;
         wb_idx_q <= '0;
         op_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         random_q <= random_d;
         op_err_q <= op_err_d;
         if (latch) begin
            op_q            <= op_type;
            info_q.entryhi  <= cp0_entryhi;
            info_q.pagemask <= '0;
            info_q.entrylo0 <= cp0_entrylo0;
            info_q.entrylo1 <= cp0_entrylo1;
            info_q.index    <= (op_type == OP_TLBWR) ? {27'b0, random_q} : cp0_index;
         end
         if (capture) begin
            wb_hi_q  <= tlb_res.entryhi;
            wb_lo0_q <= tlb_res.entrylo0;
            wb_lo1_q <= tlb_res.entrylo1;
            wb_idx_q <= tlb_res.index;
         end
      end
   end

   assign tlb_info    = info_q;
   assign wb_entryhi  = wb_hi_q;
   assign wb_entrylo0 = wb_lo0_q;
   assign wb_entrylo1 = wb_lo1_q;
   assign wb_index    = wb_idx_q;
   assign random      = random_q;
   assign op_err      = op_err_q;

endmodule
